// File: rtl/inv_sbox_serial_if.sv
// Handshake bundle for the serial InvSubBytes unit: a state goes in on the
// in_* side and the substituted state comes back on the out_* side.
interface inv_sbox_serial_if #(
  parameter int NBYTES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_data;

  // Round controller side: offers a state and consumes the result.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Substitution unit side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_sbox_serial.sv
// Serialized AES InvSubBytes. The accepted state is shadowed, each byte is
// pushed through a registered inverse S-box one per cycle, and the LUT output
// is written into the result register one edge later. Byte 0 is the MSB byte.
module inv_sbox_serial #(
  parameter int NBYTES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  inv_sbox_serial_if.slave   sif,
  output logic               busy_o
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Full AES inverse S-box, row = high nibble, column = low nibble.
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  state_e           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;       // byte currently presented to the LUT
  logic [7:0]       lut_q,      lut_d;       // registered S-box output
  logic             lut_vld_q,  lut_vld_d;   // lut_q holds a byte still to be written
  logic             last_q,     last_d;      // final byte has been sampled into lut_q
  logic [W-1:0]     shadow_q,   shadow_d;
  logic [W-1:0]     out_data_q, out_data_d;

  logic [7:0]       sel_byte;
  logic [CW-1:0]    wr_idx;

  // Handshake outputs decode directly from the registered state.
  assign sif.in_ready  = (state_q == ST_IDLE);
  assign sif.out_valid = (state_q == ST_DONE);
  assign sif.out_data  = out_data_q;
  assign busy_o        = (state_q == ST_RUN) || (state_q == ST_DONE);

  // Byte mux feeding the LUT, and the result slot the LUT register lands in.
  // Once the counter has parked on the last byte the pending write targets it.
  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (cnt_q == CW'(i)) sel_byte = shadow_q[W-1-8*i -: 8];
    end
    wr_idx = last_q ? CNT_LAST : (cnt_q - CW'(1));
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  // NOTE: every _d gets its hold value first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lut_d      = lut_q;
    lut_vld_d  = lut_vld_q;
    last_d     = last_q;
    shadow_d   = shadow_q;
    out_data_d = out_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sif.in_valid) begin
          shadow_d  = sif.in_data;
          cnt_d     = '0;
          lut_vld_d = 1'b0;
          last_d    = 1'b0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        if (lut_vld_q) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (wr_idx == CW'(i)) out_data_d[W-1-8*i -: 8] = lut_q;
          end
        end
        if (!last_q) begin
          lut_d     = INV_SBOX[sel_byte];
          lut_vld_d = 1'b1;
          if (cnt_q == CNT_LAST) last_d = 1'b1;
          else                   cnt_d  = cnt_q + CW'(1);
        end else begin
          // This edge writes the final byte; the result is complete.
          lut_vld_d = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        if (sif.out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  // NOTE: the wide shadow and result registers are reset too, so an aborted
  // transaction leaves nothing behind and no X ever reaches out_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lut_q      <= 8'h00;
      lut_vld_q  <= 1'b0;
      last_q     <= 1'b0;
      shadow_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lut_q      <= lut_d;
      lut_vld_q  <= lut_vld_d;
      last_q     <= last_d;
      shadow_q   <= shadow_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_inv_sbox_serial.sv
// Self-checking bench for inv_sbox_serial. The reference inverse S-box is
// derived arithmetically (GF(2^8) inverse plus affine map, then inverted), and
// a transaction-level model predicts the outputs on every cycle.
module tb_inv_sbox_serial;

  localparam int NB = 16;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  inv_sbox_serial_if #(.NBYTES(NB)) bus ();

  inv_sbox_serial #(.NBYTES(NB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sif    (bus),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference S-box built from field arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  // Replace the first k bytes of base with InvSubBytes of the matching src bytes.
  function automatic logic [W-1:0] merge(input logic [W-1:0] base, input logic [W-1:0] src, input int k);
    logic [W-1:0] r = base;
    for (int i = 0; i < k; i++) r[W-1-8*i -: 8] = inv_tab[src[W-1-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] inv_sub(input logic [W-1:0] d);
    return merge('0, d, NB);
  endfunction

  function automatic logic [W-1:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- transaction-level model ----------------
  bit           m_active = 1'b0;
  bit           m_valid  = 1'b0;
  int           m_age    = 0;
  logic [W-1:0] m_in     = '0;
  logic [W-1:0] m_base   = '0;
  logic [W-1:0] m_out    = '0;

  // Model advance: a state accepted at edge E0 has k = age-1 bytes written by
  // edge E(age), and the result is announced at E(NB+1).
  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_age    = 0;
      m_out    = '0;
    end else if (!m_active) begin
      if (bus.in_valid) begin
        m_active = 1'b1;
        m_in     = bus.in_data;
        m_base   = m_out;
        m_age    = 0;
      end
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid  = 1'b0;
        m_active = 1'b0;
      end
    end else begin
      m_age++;
      m_out = merge(m_base, m_in, (m_age - 1 > NB) ? NB : m_age - 1);
      if (m_age == NB + 1) m_valid = 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc in_ready",  W'(bus.in_ready),  W'(!m_active));
      check("cyc out_valid", W'(bus.out_valid), W'(m_valid));
      check("cyc busy",      W'(busy),          W'(m_active));
      check("cyc out_data",  bus.out_data,      m_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Runs one transaction from a negedge; returns the result and the number of
  // cycles from the accept edge to out_valid, holding out_ready low for hold cycles.
  task automatic run_txn(input logic [W-1:0] d, input int hold,
                         output logic [W-1:0] res, output int lat);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept ready", W'(bus.in_ready), W'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus.out_valid && lat < 100);
    check("out_valid timeout", W'(bus.out_valid), W'(1));
    res = bus.out_data;
    repeat (hold) @(negedge clk);
    check("held out_data", bus.out_data, res);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] fill(input logic [7:0] b);
    return {NB{b}};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] res, d, exp;
    int lat, n;

    // Build the reference tables and pin them with known values.
    for (int x = 0; x < 256; x++) fwd_tab[x] = fwd_sbox(8'(x));
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    check("model fwd 00", W'(fwd_tab[8'h00]), W'(8'h63));
    check("model fwd 53", W'(fwd_tab[8'h53]), W'(8'hed));
    check("model inv 63", W'(inv_tab[8'h63]), W'(8'h00));
    check("model inv 7C", W'(inv_tab[8'h7c]), W'(8'h01));
    check("model inv 00", W'(inv_tab[8'h00]), W'(8'h52));
    check("model inv ED", W'(inv_tab[8'hed]), W'(8'h53));
    check("model inv 16", W'(inv_tab[8'h16]), W'(8'hff));
    check("model inv 52", W'(inv_tab[8'h52]), W'(8'h48));

    // Reset then idle.
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready",  W'(bus.in_ready),  W'(1));
    check("reset out_valid", W'(bus.out_valid), W'(0));
    check("reset out_data",  bus.out_data,      '0);
    check("reset busy",      W'(busy),          W'(0));

    // Single transaction with the first forward S-box row.
    run_txn(128'h637C777BF26B6FC53001672BFED7AB76, 0, res, lat);
    check("single latency", W'(lat), W'(17));
    check("single data", res, 128'h000102030405060708090A0B0C0D0E0F);
    check("single back idle", W'(bus.in_ready), W'(1));

    // Backpressure: hold out_ready low for 10 cycles after out_valid.
    run_txn(fill(8'h16), 10, res, lat);
    check("bp data", res, fill(8'hff));
    check("bp out_data retained", bus.out_data, fill(8'hff));
    check("bp in_ready after hs", W'(bus.in_ready), W'(1));
    check("bp out_valid after hs", W'(bus.out_valid), W'(0));

    // Input stability: random in_valid/in_data activity during RUN.
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.in_data  = rand_state();
      n++;
    end while (!bus.out_valid && n < 100);
    bus.in_valid = 1'b0;
    check("stab out_valid", W'(bus.out_valid), W'(1));
    check("stab data", bus.out_data, fill(8'h52));
    check("stab in_ready in DONE", W'(bus.in_ready), W'(0));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);

    // Reset in the middle of a run.
    bus.in_valid = 1'b1;
    bus.in_data  = rand_state();
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst in_ready",  W'(bus.in_ready),  W'(1));
    check("midrst out_valid", W'(bus.out_valid), W'(0));
    check("midrst out_data",  bus.out_data,      '0);
    check("midrst busy",      W'(busy),          W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(fill(8'hed), 1, res, lat);
    check("midrst next data", res, fill(8'h53));

    // Round trip over all 256 byte values.
    for (int t = 0; t < 16; t++) begin
      for (int j = 0; j < NB; j++) begin
        d[W-1-8*j -: 8]   = fwd_tab[16*t + j];
        exp[W-1-8*j -: 8] = 8'(16*t + j);
      end
      run_txn(d, int'($urandom_range(0, 2)), res, lat);
      check("roundtrip", res, exp);
    end

    // Random states with random backpressure.
    for (int t = 0; t < 8; t++) begin
      d = rand_state();
      run_txn(d, int'($urandom_range(0, 4)), res, lat);
      check("random data", res, inv_sub(d));
      check("random latency", W'(lat), W'(NB + 1));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
